link_sequencer: RTL and testbench

LINK_SEQUENCER -- requirements
Module: link_sequencer

---
 rtl/link_sequencer_if.sv | 30 +++
 rtl/link_sequencer.sv | 134 +++++++++++++
 tb/tb_link_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/link_sequencer_if.sv
// Requester/peer signal bundle for link_sequencer.
// The slave side is the sequencer; the master side is the requester plus peer model.
interface link_sequencer_if #(
    parameter int LEN_W = 8,
    parameter int DLY_W = 4
);
    logic             REQ;
    logic [LEN_W-1:0] LEN;
    logic [DLY_W-1:0] DELAY;
    logic             START;
    logic             RESET;
    logic             Y;
    logic             X;
    logic             READY;
    logic             PEER_NRST;
    logic             BUSY;
    logic             DONE;
    logic             ERR;
    logic [LEN_W-1:0] COUNT;

    modport slave (
        input  REQ, LEN, DELAY, START, RESET, Y,
        output X, READY, PEER_NRST, BUSY, DONE, ERR, COUNT
    );

    modport master (
        output REQ, LEN, DELAY, START, RESET, Y,
        input  X, READY, PEER_NRST, BUSY, DONE, ERR, COUNT
    );
endinterface

// File: rtl/link_sequencer.sv
// Sequences one length-counted transfer with a peer FSM: arm, optional READY delay,
// beat counting, and a one-cycle DONE/ERR wrap-up that also resets the peer.
module link_sequencer #(
    parameter int LEN_W = 8,
    parameter int DLY_W = 4,
    parameter int TMO   = 16
) (
    input  logic           CLK,
    input  logic           N_RESET,
    link_sequencer_if.slave lnk
);
    localparam int TMO_W = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        WAIT = 3'd2,
        RDY  = 3'd3,
        XFER = 3'd4,
        FIN  = 3'd5,
        FAIL = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, count_q;
    logic [DLY_W-1:0] dly_q, dcnt_q;
    logic [TMO_W-1:0] tmo_q;
    logic             last_beat, tmo_hit, accept;
    logic             x_o, ready_o, peer_nrst_o, busy_o, done_o, err_o;

    // Compare one bit wider so LEN of all ones never aliases with a wrapped count.
    assign last_beat = ({1'b0, count_q} + 1'b1) == {1'b0, len_q};
    assign tmo_hit   = tmo_q == TMO_W'(TMO);
    assign accept    = (state_q == IDLE) && lnk.REQ && (lnk.LEN != '0);

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        x_o         = 1'b0;
        ready_o     = 1'b0;
        peer_nrst_o = 1'b1;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        case (state_q)
            IDLE: begin
                if (lnk.REQ) state_d = (lnk.LEN != '0) ? ARM : FAIL;
            end
            ARM: begin
                x_o    = 1'b1;
                busy_o = 1'b1;
                if (lnk.START)   state_d = (dly_q != '0) ? WAIT : RDY;
                else if (tmo_hit) state_d = FAIL;
            end
            WAIT: begin
                x_o    = 1'b1;
                busy_o = 1'b1;
                if (lnk.RESET)                 state_d = FAIL;
                else if (dcnt_q == DLY_W'(1))  state_d = RDY;
            end
            RDY: begin
                x_o     = 1'b1;
                ready_o = 1'b1;
                busy_o  = 1'b1;
                if (lnk.RESET)    state_d = FAIL;
                else if (lnk.Y)   state_d = last_beat ? FIN : XFER;
                else if (tmo_hit) state_d = FAIL;
            end
            XFER: begin
                x_o     = 1'b1;
                ready_o = 1'b1;
                busy_o  = 1'b1;
                if (lnk.RESET)                state_d = FAIL;
                else if (lnk.Y && last_beat)  state_d = FIN;
            end
            FIN: begin
                busy_o      = 1'b1;
                done_o      = 1'b1;
                peer_nrst_o = 1'b0;
                state_d     = IDLE;
            end
            FAIL: begin
                busy_o      = 1'b1;
                err_o       = 1'b1;
                peer_nrst_o = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Timeout counter restarts on every state change; only ARM and RDY let it run.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            tmo_q   <= '0;
            len_q   <= '0;
            dly_q   <= '0;
            dcnt_q  <= '0;
            count_q <= '0;
        end else begin
            if (state_q != state_d)
                tmo_q <= '0;
            else if (state_q == ARM || state_q == RDY)
                tmo_q <= tmo_q + 1'b1;

            if (accept) begin
                len_q   <= lnk.LEN;
                dly_q   <= lnk.DELAY;
                count_q <= '0;
            end

            if (state_q == ARM && state_d == WAIT)
                dcnt_q <= dly_q;
            else if (state_q == WAIT)
                dcnt_q <= dcnt_q - 1'b1;

            // A peer fall-back on the same cycle as Y aborts without counting the beat.
            if ((state_q == RDY || state_q == XFER) && lnk.Y && !lnk.RESET)
                count_q <= count_q + 1'b1;
        end
    end

    assign lnk.X         = x_o;
    assign lnk.READY     = ready_o;
    assign lnk.PEER_NRST = peer_nrst_o;
    assign lnk.BUSY      = busy_o;
    assign lnk.DONE      = done_o;
    assign lnk.ERR       = err_o;
    assign lnk.COUNT     = count_q;
endmodule

// File: tb/tb_link_sequencer.sv
// Randomized bench: a peer model drives each transfer while a monitor scores every
// DONE/ERR pulse against outcomes predicted from the transfer plan.
module tb_link_sequencer;
    localparam int LEN_W = 8;
    localparam int DLY_W = 4;
    localparam int TMO   = 16;

    typedef struct {
        bit done;
        int cnt;
        int arm;
        int wt;
    } exp_t;

    logic CLK;
    logic N_RESET;
    int   errors = 0;
    int   checks = 0;
    int   prev_count = 0;
    exp_t q[$];

    link_sequencer_if #(.LEN_W(LEN_W), .DLY_W(DLY_W)) ifc ();

    link_sequencer #(.LEN_W(LEN_W), .DLY_W(DLY_W), .TMO(TMO)) dut (
        .CLK     (CLK),
        .N_RESET (N_RESET),
        .lnk     (ifc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Outcome of one transfer derived from its plan: k = ARM cycle on which START is
    // offered, f = RDY cycle of the first beat, r = beats before the peer falls back.
    task automatic run_txn(input int len, input int dly, input int k, input int f,
                           input int r, input bit dense);
        exp_t e;
        int   arm_i, rdy_i, dbeats, guard;
        bit   started;
        e.done = 0; e.cnt = prev_count; e.arm = 0; e.wt = 0;
        if (len != 0) begin
            e.cnt = 0;
            if (k > TMO) e.arm = TMO + 1;
            else begin
                e.arm = k + 1;
                e.wt  = dly;
                if (r < len && r == 0)  e.cnt = 0;
                else if (f > TMO)       e.cnt = 0;
                else if (r < len)       e.cnt = r;
                else begin e.done = 1;  e.cnt = len; end
            end
        end
        prev_count = e.cnt;

        guard = 0;
        while (ifc.BUSY && guard < 100) begin @(negedge CLK); guard++; end
        if (guard >= 100) bound_fail("idle_before_req");
        q.push_back(e);
        ifc.REQ = 1'b1; ifc.LEN = LEN_W'(len); ifc.DELAY = DLY_W'(dly);
        @(negedge CLK);
        ifc.REQ = 1'b0;
        arm_i = 0; rdy_i = 0; dbeats = 0; guard = 0; started = 0;
        forever begin
            ifc.START = 1'b0; ifc.Y = 1'b0; ifc.RESET = 1'b0;
            if (!ifc.BUSY) break;
            if (ifc.X && !ifc.READY && !started) begin
                if (arm_i == k) begin ifc.START = 1'b1; started = 1; end
                arm_i++;
            end
            if (ifc.READY) begin
                if (dbeats == r && r < len) ifc.RESET = 1'b1;
                else if (rdy_i == f || (rdy_i > f && (dense || $urandom_range(0, 3) != 0))) begin
                    ifc.Y = 1'b1;
                    dbeats++;
                end
                rdy_i++;
            end
            guard++;
            if (guard > 2000) begin bound_fail("txn_end"); break; end
            @(negedge CLK);
        end
    endtask

    // Monitor: tallies ARM and WAIT residency, scores every completion pulse.
    initial begin
        bit   start_seen, post;
        int   arm_n, wt_n;
        exp_t e;
        start_seen = 0; post = 0; arm_n = 0; wt_n = 0;
        forever begin
            @(posedge CLK); #1;
            if (!N_RESET) begin
                start_seen = 0; post = 0; arm_n = 0; wt_n = 0;
                continue;
            end
            if (post) begin
                chk("idle_after_pulse", int'(ifc.BUSY | ifc.DONE | ifc.ERR), 0);
                chk("peer_nrst_release", int'(ifc.PEER_NRST), 1);
                post = 0;
            end
            if (ifc.DONE || ifc.ERR) begin
                if (q.size() == 0) bound_fail("unexpected_pulse");
                else begin
                    e = q.pop_front();
                    chk("done", int'(ifc.DONE), int'(e.done));
                    chk("err", int'(ifc.ERR), int'(!e.done));
                    chk("count", int'(ifc.COUNT), e.cnt);
                    chk("arm_cycles", arm_n, e.arm);
                    chk("wait_cycles", wt_n, e.wt);
                    chk("x_ready_in_pulse", int'(ifc.X | ifc.READY), 0);
                    chk("peer_nrst_pulse", int'(ifc.PEER_NRST), 0);
                end
                post = 1;
            end else if (!ifc.BUSY) begin
                start_seen = 0; arm_n = 0; wt_n = 0;
            end else begin
                if (ifc.START) start_seen = 1;
                if (ifc.X && !ifc.READY) begin
                    if (start_seen) wt_n++;
                    else            arm_n++;
                end
            end
        end
    end

    initial begin
        int len, dly, k, f, r, guard;
        ifc.REQ = 0; ifc.LEN = '0; ifc.DELAY = '0;
        ifc.START = 0; ifc.RESET = 0; ifc.Y = 0;
        N_RESET = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_x", int'(ifc.X), 0);
        chk("rst_ready", int'(ifc.READY), 0);
        chk("rst_peer_nrst", int'(ifc.PEER_NRST), 1);
        chk("rst_busy", int'(ifc.BUSY), 0);
        chk("rst_done", int'(ifc.DONE), 0);
        chk("rst_err", int'(ifc.ERR), 0);
        chk("rst_count", int'(ifc.COUNT), 0);
        N_RESET = 1'b1;
        @(negedge CLK);

        run_txn(3, 2, 1, 0, 3, 1);           // nominal transfer
        run_txn(0, 5, 0, 0, 0, 1);           // zero length rejected, COUNT held
        run_txn(2, 0, TMO + 1, 0, 2, 1);     // START never arrives
        run_txn(2, 0, TMO, 0, 2, 1);         // START on the expiry cycle
        run_txn(4, 1, 0, 0, 2, 1);           // peer falls back after 2 beats
        run_txn(3, 0, 0, TMO, 3, 0);         // first beat on the RDY expiry cycle
        run_txn(3, 0, 0, TMO + 1, 3, 0);     // RDY timeout

        // Asynchronous reset pulse while in RDY.
        @(negedge CLK);
        ifc.REQ = 1; ifc.LEN = 8'd5; ifc.DELAY = 4'd1;
        @(negedge CLK); ifc.REQ = 0; ifc.START = 1;
        @(negedge CLK); ifc.START = 0;
        @(negedge CLK);
        chk("pre_reset_ready", int'(ifc.READY), 1);
        #1 N_RESET = 1'b0;
        #1;
        chk("async_x", int'(ifc.X), 0);
        chk("async_ready", int'(ifc.READY), 0);
        chk("async_peer_nrst", int'(ifc.PEER_NRST), 1);
        chk("async_busy", int'(ifc.BUSY), 0);
        chk("async_count", int'(ifc.COUNT), 0);
        #1 N_RESET = 1'b1;
        prev_count = 0;
        repeat (3) @(negedge CLK);

        run_txn(2, 3, 2, 1, 2, 0);           // clean start after reset
        run_txn(255, 0, 0, 0, 255, 1);       // full-range length

        for (int i = 0; i < 40; i++) begin
            len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
            dly = int'($urandom_range(0, 15));
            case ($urandom_range(0, 7))
                0:       k = TMO;
                1:       k = TMO + 1;
                default: k = int'($urandom_range(0, 3));
            endcase
            case ($urandom_range(0, 7))
                0:       f = TMO;
                1:       f = TMO + 1;
                default: f = int'($urandom_range(0, 2));
            endcase
            r = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : len;
            run_txn(len, dly, k, f, r, $urandom_range(0, 1) == 1);
        end

        guard = 0;
        while (q.size() != 0 && guard < 200) begin @(negedge CLK); guard++; end
        if (q.size() != 0) bound_fail("scoreboard_drain");
        repeat (3) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
